rng_health_monitor: RTL and testbench
=====================================

Name: rng_health_monitor

Overview:
Consumer-side companion to the randomizer. Accepts its 2-bit random symbol stream and runs continuous health tests on it: a repetition count test (RCT) and an adaptive proportion test (APT). While the source is healthy, it packs symbols into bytes for downstream use. It sits between the randomizer output and the top-level uo_out/uio pins, and it gates entropy delivery with a sticky fail state.

Parameters:
RCT_CUTOFF, 8, number of consecutive identical symbols that counts as an RCT failure (legal range 2..255).
APT_WINDOW, 64, APT window length in accepted symbols (power of two, 4..256).
APT_CUTOFF, 40, number of occurrences of the window's first symbol that counts as an APT failure (must satisfy 2 <= APT_CUTOFF <= APT_WINDOW).

Ports:
i_clk, input, 1, clock.
i_rst_n, input, 1, synchronous active-low reset.
i_en, input, 1, monitor enable; symbols are ignored while low.
i_valid, input, 1, i_sample is valid this cycle.
i_sample, input, 2, random symbol from the randomizer.
i_clear, input, 1, synchronous clear of the fail state and all test state.
o_healthy, output, 1, high only in RUN.
o_rct_fail, output, 1, sticky RCT failure flag.
o_apt_fail, output, 1, sticky APT failure flag.
o_byte, output, 8, packed entropy byte.
o_byte_valid, output, 1, one-cycle strobe qualifying o_byte.
o_hist, output, 32, per-symbol window histogram; driven only when RNG_MON_HIST_EN is defined, else 0.

Behaviour:
- Reset and sampling:
  - Reset is synchronous and active-low: a rising i_clk edge with i_rst_n=0 resets the block.
  - A symbol is accepted when i_en & i_valid is high at a rising edge.
  - Reset values: state=STARTUP; all counters 0; o_healthy=0, o_rct_fail=0, o_apt_fail=0, o_byte=0, o_byte_valid=0, o_hist=0.
- States:
  - STARTUP: runs the tests. When a full window of APT_WINDOW symbols completes with no failure, go to RUN.
  - RUN: o_healthy=1 and bytes are emitted.
  - FAIL: any test failure in STARTUP or RUN goes here. FAIL is sticky; only i_clear or reset exits it, back to STARTUP.
- RCT:
  - Keep last symbol and run count rct_cnt.
  - On the first accepted symbol after reset or clear: last=sample, rct_cnt=1.
  - Otherwise, a symbol equal to last gives rct_cnt+1, saturating at RCT_CUTOFF. A different symbol gives rct_cnt=1 and last=sample.
  - When rct_cnt reaches RCT_CUTOFF, o_rct_fail=1 on the cycle after the accepting edge.
- APT:
  - Window index runs 0..APT_WINDOW-1 and wraps.
  - At index 0: ref=sample, apt_cnt=1. At other indices, a match gives apt_cnt+1, saturating.
  - When apt_cnt reaches APT_CUTOFF, o_apt_fail=1 on the cycle after the accepting edge.
  - The window end is the acceptance at index APT_WINDOW-1. The STARTUP->RUN check uses the fail status including that symbol.
- Latency: failure flags, the state change and o_healthy all update on the same edge, 1 cycle after the offending symbol. Both flags can set on the same edge.
- Byte packer (RUN only):
  - Shift left by 2, new symbol into bits [1:0].
  - On the 4th accepted symbol, o_byte updates and o_byte_valid pulses high for exactly 1 cycle.
  - The packer count clears on entry to RUN. The first symbol packed is the first one accepted after RUN is entered; the STARTUP-completing symbol is not packed.
  - If the 4th symbol also causes a failure, the byte is not emitted and o_byte holds its old value.
  - Partial bytes are discarded on FAIL or clear.
- i_clear:
  - Returns to STARTUP from any state. Clears both flags, all counters and the packer. o_byte is retained.
  - A symbol presented on the same cycle as i_clear is dropped.
- i_en low: state, counters and flags hold; o_byte_valid=0.

Optional Feature:
RNG_MON_HIST_EN:
- Defined:
  - Four 8-bit per-symbol counters run over each APT window. Each saturates at 255, which is reachable only when APT_WINDOW=256.
  - At window end, o_hist is latched as {cnt3,cnt2,cnt1,cnt0}, including the final symbol, and the counters restart.
  - Counters and o_hist clear on reset; the counters also clear on i_clear, while o_hist holds.
- Undefined: no histogram logic is built and o_hist is tied to 0.

Test Plan:
- Reset with i_rst_n=0 for 2 cycles -> all outputs 0 and state STARTUP.
- Feed 64 symbols cycling 0,1,2,3 (defaults) -> o_healthy rises 1 cycle after the 64th. The next 4 symbols 1,2,3,0 -> o_byte=8'h6C with a single o_byte_valid pulse.
- In RUN, feed 8 consecutive symbol 2 -> o_rct_fail=1 and o_healthy=0 one cycle after the 8th; no byte is emitted even on a byte boundary. A later 7-long run after clear passes.
- New window starts with symbol 1. Feed 40 ones in that window, interleaved to avoid an RCT run (1,1,0,1,1,0,...) -> o_apt_fail=1 after the 40th one, while o_rct_fail stays 0.
- Assert i_clear in FAIL together with i_valid -> flags are 0 next cycle, the state is STARTUP, the sample is dropped, and a full clean window is required before o_healthy returns.
- With RNG_MON_HIST_EN defined, window of 64 symbols cycling 0..3 -> o_hist=32'h10101010. With i_en low mid-window, counts freeze.

Source files
------------

// File: rtl/rng_health_monitor.sv
// Continuous RCT/APT health monitor for a 2-bit random symbol stream; packs symbols into bytes while healthy.
// Optional per-symbol window histogram on o_hist is built when RNG_MON_HIST_EN is defined.
module rng_health_monitor #(
    parameter int RCT_CUTOFF = 8,
    parameter int APT_WINDOW = 64,
    parameter int APT_CUTOFF = 40
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    input  logic        i_valid,
    input  logic [1:0]  i_sample,
    input  logic        i_clear,
    output logic        o_healthy,
    output logic        o_rct_fail,
    output logic        o_apt_fail,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    output logic [31:0] o_hist
);
    localparam int IDX_W = $clog2(APT_WINDOW);
    localparam int AC_W  = $clog2(APT_WINDOW + 1);

    typedef enum logic [1:0] {STARTUP, RUN, FAILED} state_t;

    state_t            state;
    logic [1:0]        last_sym;
    logic [7:0]        rct_cnt;
    logic [1:0]        ref_sym;
    logic [AC_W-1:0]   apt_cnt;
    logic [IDX_W-1:0]  apt_idx;
    logic [7:0]        pack_sh;
    logic [1:0]        pack_cnt;

    logic              accept;
    logic [7:0]        rct_next;
    logic [AC_W-1:0]   apt_next;
    logic              rct_hit;
    logic              apt_hit;
    logic              win_end;
    logic [7:0]        packed_byte;

    function automatic logic [7:0] rct_inc(input logic [7:0] c);
        return (c >= 8'(RCT_CUTOFF)) ? 8'(RCT_CUTOFF) : c + 8'd1;
    endfunction

    function automatic logic [AC_W-1:0] apt_inc(input logic [AC_W-1:0] c);
        return (c >= AC_W'(APT_CUTOFF)) ? AC_W'(APT_CUTOFF) : c + AC_W'(1);
    endfunction

    // Symbols are not consumed in FAILED; only clear or reset leaves it.
    always_comb begin
        accept      = i_en & i_valid & (state != FAILED);
        win_end     = (apt_idx == IDX_W'(APT_WINDOW - 1));
        packed_byte = {pack_sh[5:0], i_sample};
        if (rct_cnt == 8'd0 || i_sample != last_sym)
            rct_next = 8'd1;
        else
            rct_next = rct_inc(rct_cnt);
        if (apt_idx == '0)
            apt_next = AC_W'(1);
        else if (i_sample == ref_sym)
            apt_next = apt_inc(apt_cnt);
        else
            apt_next = apt_cnt;
        rct_hit = (rct_next == 8'(RCT_CUTOFF));
        apt_hit = (apt_next == AC_W'(APT_CUTOFF));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= STARTUP;
            last_sym     <= 2'd0;
            rct_cnt      <= 8'd0;
            ref_sym      <= 2'd0;
            apt_cnt      <= '0;
            apt_idx      <= '0;
            pack_sh      <= 8'd0;
            pack_cnt     <= 2'd0;
            o_healthy    <= 1'b0;
            o_rct_fail   <= 1'b0;
            o_apt_fail   <= 1'b0;
            o_byte       <= 8'd0;
            o_byte_valid <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            if (i_clear) begin
                state      <= STARTUP;
                last_sym   <= 2'd0;
                rct_cnt    <= 8'd0;
                ref_sym    <= 2'd0;
                apt_cnt    <= '0;
                apt_idx    <= '0;
                pack_sh    <= 8'd0;
                pack_cnt   <= 2'd0;
                o_healthy  <= 1'b0;
                o_rct_fail <= 1'b0;
                o_apt_fail <= 1'b0;
            end else if (accept) begin
                last_sym <= i_sample;
                rct_cnt  <= rct_next;
                apt_cnt  <= apt_next;
                apt_idx  <= apt_idx + IDX_W'(1);
                if (apt_idx == '0)
                    ref_sym <= i_sample;
                if (rct_hit || apt_hit) begin
                    state      <= FAILED;
                    o_healthy  <= 1'b0;
                    o_rct_fail <= o_rct_fail | rct_hit;
                    o_apt_fail <= o_apt_fail | apt_hit;
                    pack_cnt   <= 2'd0;
                end else if (state == STARTUP) begin
                    if (win_end) begin
                        state     <= RUN;
                        o_healthy <= 1'b1;
                        pack_cnt  <= 2'd0;
                    end
                end else begin
                    pack_sh  <= packed_byte;
                    pack_cnt <= pack_cnt + 2'd1;
                    if (pack_cnt == 2'd3) begin
                        o_byte       <= packed_byte;
                        o_byte_valid <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef RNG_MON_HIST_EN
    logic [7:0] hist_cnt [4];
    logic [7:0] hist_nxt [4];

    function automatic logic [7:0] hist_inc(input logic [7:0] c);
        return (c == 8'hFF) ? 8'hFF : c + 8'd1;
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++)
            hist_nxt[k] = (i_sample == 2'(k)) ? hist_inc(hist_cnt[k]) : hist_cnt[k];
    end

    // Snapshot includes the window's final symbol; counters restart for the next window.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 4; k++) hist_cnt[k] <= 8'd0;
            o_hist <= 32'd0;
        end else if (i_clear) begin
            for (int k = 0; k < 4; k++) hist_cnt[k] <= 8'd0;
        end else if (accept) begin
            if (win_end) begin
                o_hist <= {hist_nxt[3], hist_nxt[2], hist_nxt[1], hist_nxt[0]};
                for (int k = 0; k < 4; k++) hist_cnt[k] <= 8'd0;
            end else begin
                for (int k = 0; k < 4; k++) hist_cnt[k] <= hist_nxt[k];
            end
        end
    end
`else
    assign o_hist = 32'd0;
`endif

endmodule

// File: tb/tb_rng_health_monitor.sv
// Directed bench for rng_health_monitor: expected bytes go into a queue, a negedge monitor pops on o_byte_valid.
module tb_rng_health_monitor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        valid;
    logic [1:0]  sample;
    logic        clear;
    logic        healthy;
    logic        rct_fail;
    logic        apt_fail;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [31:0] hist;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    rng_health_monitor dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_valid      (valid),
        .i_sample     (sample),
        .i_clear      (clear),
        .o_healthy    (healthy),
        .o_rct_fail   (rct_fail),
        .o_apt_fail   (apt_fail),
        .o_byte       (byte_out),
        .o_byte_valid (byte_valid),
        .o_hist       (hist)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] s);
        en     = 1'b1;
        valid  = 1'b1;
        sample = s;
        @(posedge clk);
        #1;
        valid  = 1'b0;
    endtask

    // Byte scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && byte_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL byte_unexpected: got 0x%0h expected no strobe", byte_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (byte_out !== e) begin
                    n_fail++;
                    $display("FAIL byte_value: got 0x%0h expected 0x%0h", byte_out, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] hist_b, hist_f;
        logic [7:0]  pat [3];
`ifdef RNG_MON_HIST_EN
        hist_b = 32'h10101010;
        hist_f = 32'h150E0E0F;
`else
        hist_b = 32'h0;
        hist_f = 32'h0;
`endif
        pat[0] = 8'h51; pat[1] = 8'h45; pat[2] = 8'h14;

        rst_n = 1'b0; en = 1'b1; valid = 1'b1; sample = 2'd2; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_healthy", {31'd0, healthy}, 32'd0);
        check("rst_rct", {31'd0, rct_fail}, 32'd0);
        check("rst_apt", {31'd0, apt_fail}, 32'd0);
        check("rst_byte", {24'd0, byte_out}, 32'd0);
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_hist", hist, 32'd0);
        valid = 1'b0; en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First window: 0,1,2,3 cycling brings the monitor into RUN.
        for (int i = 0; i < 64; i++) begin
            send(2'(i % 4));
            if (i == 62) check("startup_not_early", {31'd0, healthy}, 32'd0);
        end
        check("startup_healthy", {31'd0, healthy}, 32'd1);
        check("startup_hist", hist, hist_b);

        exp_q.push_back(8'h6C);
        send(2'd1); send(2'd2); send(2'd3); send(2'd0);
        check("run_healthy", {31'd0, healthy}, 32'd1);

        // Eight 2s: first four form 0xAA, the eighth trips the RCT on a byte boundary.
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 8; i++) begin
            send(2'd2);
            if (i == 6) check("rct_not_early", {31'd0, rct_fail}, 32'd0);
        end
        check("rct_fail", {31'd0, rct_fail}, 32'd1);
        check("rct_unhealthy", {31'd0, healthy}, 32'd0);
        check("rct_apt_quiet", {31'd0, apt_fail}, 32'd0);
        check("rct_byte_held", {24'd0, byte_out}, 32'hAA);
        send(2'd1);
        check("fail_sticky", {31'd0, rct_fail}, 32'd1);

        // Clear with a symbol present: that 3 must be dropped or the next run of 7 becomes 8.
        en = 1'b1; valid = 1'b1; sample = 2'd3; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; valid = 1'b0;
        check("clear_rct", {31'd0, rct_fail}, 32'd0);
        check("clear_apt", {31'd0, apt_fail}, 32'd0);
        check("clear_healthy", {31'd0, healthy}, 32'd0);
        check("clear_byte_kept", {24'd0, byte_out}, 32'hAA);

        for (int i = 0; i < 7; i++) send(2'd3);
        en = 1'b0; valid = 1'b1; sample = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0; en = 1'b1;
        check("run7_pass", {31'd0, rct_fail}, 32'd0);
        for (int i = 0; i < 57; i++) begin
            send(2'(i % 4));
            if (i == 55) check("rewindow_not_early", {31'd0, healthy}, 32'd0);
        end
        check("rewindow_healthy", {31'd0, healthy}, 32'd1);
        check("rewindow_rct", {31'd0, rct_fail}, 32'd0);
        check("rewindow_apt", {31'd0, apt_fail}, 32'd0);
        check("rewindow_hist", hist, hist_f);

        // APT: window opens on 1, pattern 1,1,0 reaches 40 ones on symbol 59.
        for (int b = 0; b < 14; b++) exp_q.push_back(pat[b % 3]);
        for (int k = 1; k <= 59; k++) begin
            send((k % 3 == 0) ? 2'd0 : 2'd1);
            if (k == 58) check("apt_not_early", {31'd0, apt_fail}, 32'd0);
        end
        check("apt_fail", {31'd0, apt_fail}, 32'd1);
        check("apt_rct_quiet", {31'd0, rct_fail}, 32'd0);
        check("apt_unhealthy", {31'd0, healthy}, 32'd0);
        check("apt_byte_held", {24'd0, byte_out}, 32'h45);
        check("apt_hist_held", hist, hist_f);

        repeat (4) @(posedge clk);
        #1;
        check("bytes_outstanding", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
